// File: rtl/button_pio_in_pkg.sv
// rtl/button_pio_in_pkg.sv - shared constants and helpers for the button input PIO
package button_pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Counter must hold 0..cycles; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_pio_in_if.sv
// rtl/button_pio_in_if.sv - Avalon-MM slave register bus for the button input PIO
interface button_pio_in_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

endinterface

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - two-flop synchroniser, debounce counter and edge pulses for one input bit
module pio_debounce_bit
  import button_pio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync2 != state) && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
      state <= IDLE_LEVEL;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == state) begin
        cnt <= '0;
      end else if (accept) begin
        state <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Pulses are high in the cycle before state flips, so a capture register
  // sampling them sets on the very edge that updates state.
  assign rise = accept &  sync2;
  assign fall = accept & ~sync2;

endmodule

// File: rtl/button_pio_in.sv
// rtl/button_pio_in.sv - debounced push-button input PIO with edge capture and maskable irq
module button_pio_in
  import button_pio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_pio_in_if.slave       bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] clr;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .state  (state[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  if (EDGE_TYPE == EDGE_RISING) begin : g_rise
    assign edge_evt = rise;
  end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
    assign edge_evt = fall;
  end else begin : g_any
    assign edge_evt = rise | fall;
  end

  assign wr           = bus.chipselect && !bus.write_n;
  assign clr          = (wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (wr && bus.address == ADDR_IRQMASK) begin
        irqmask <= bus.writedata[WIDTH-1:0];
      end
      // A new event on the same edge as its W1C keeps the bit set.
      edgecap <= (edgecap & ~clr) | edge_evt;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = 32'(state);
      ADDR_IRQMASK: bus.readdata = 32'(irqmask);
      ADDR_EDGECAP: bus.readdata = 32'(edgecap);
      default:      bus.readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule
